// File: rtl/muldiv_seq_if.sv
// Request/response channel of the iterative multiply/divide sequencer.
// The master side issues operations and consumes results; the slave side is the sequencer.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_sel;
  logic            in_w;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_sel, in_w, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_sel, in_w, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/muldiv_seq.sv
// RV64 M-extension sequencer: one operation in flight, one bit per cycle,
// radix-2 shift-add multiply and restoring shift-subtract divide on magnitudes.
module muldiv_seq #(
  parameter int unsigned XLEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  muldiv_seq_if.slave io,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state;
  logic [2:0]        sel_r;
  logic              w_r;
  logic              neg_q;     // product sign for multiply, quotient sign for divide
  logic              neg_r;
  logic [6:0]        cnt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   op;        // multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quot;

  logic              is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [XLEN-1:0]   a_ext, b_ext, a_abs, b_abs, most_neg;
  logic [XLEN:0]     mul_sum, div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] prod_sel, prod_fix;
  logic [XLEN-1:0]   mul_res, quot_fix, rem_fix, raw_res, fix_result;

  assign io.in_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // Operand conditioning at accept.
  always_comb begin
    is_div   = io.in_sel[2];
    a_signed = is_div ? !io.in_sel[0] : (io.in_sel[1:0] != 2'b11);
    b_signed = is_div ? !io.in_sel[0] : !io.in_sel[1];
    a_ext    = io.in_w ? {{(XLEN-32){a_signed & io.in_a[31]}}, io.in_a[31:0]} : io.in_a;
    b_ext    = io.in_w ? {{(XLEN-32){b_signed & io.in_b[31]}}, io.in_b[31:0]} : io.in_b;
    sa       = a_signed & a_ext[XLEN-1];
    sb       = b_signed & b_ext[XLEN-1];
    a_abs    = sa ? -a_ext : a_ext;
    b_abs    = sb ? -b_ext : b_ext;
    most_neg = io.in_w ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = is_div && (b_ext == '0);
    div_ovf  = is_div && !io.in_sel[0] && (b_ext == '1) && (a_ext == most_neg);
  end

  // One iteration of each datapath.
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, op};
    div_shift = {rem, quot[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, op});
    rem_sub   = div_shift[XLEN-1:0] - op;
  end

  // Sign fix-up and result selection; a W product sits 32 bits up after 32 iterations.
  always_comb begin
    prod_sel   = w_r ? (prod >> 32) : prod;
    prod_fix   = neg_q ? -prod_sel : prod_sel;
    mul_res    = (sel_r[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    quot_fix   = neg_q ? -quot : quot;
    rem_fix    = neg_r ? -rem : rem;
    raw_res    = sel_r[2] ? (sel_r[1] ? rem_fix : quot_fix) : mul_res;
    fix_result = w_r ? {{(XLEN-32){raw_res[31]}}, raw_res[31:0]} : raw_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel_r         <= '0;
      w_r           <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      cnt           <= '0;
      prod          <= '0;
      op            <= '0;
      rem           <= '0;
      quot          <= '0;
      io.out_valid  <= 1'b0;
      io.out_result <= '0;
    end else if (flush) begin
      state        <= IDLE;
      io.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            sel_r <= io.in_sel;
            w_r   <= io.in_w;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            cnt   <= io.in_w ? 7'd32 : 7'd64;
            prod  <= {{XLEN{1'b0}}, b_abs};
            op    <= is_div ? b_abs : a_abs;
            rem   <= '0;
            quot  <= io.in_w ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
            // Special cases preload final unsigned values and bypass CALC.
            if (div_zero) begin
              quot  <= '1;
              rem   <= a_ext;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FIX;
            end else if (div_ovf) begin
              quot  <= a_ext;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FIX;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (sel_r[2]) begin
            rem  <= div_ge ? rem_sub : div_shift[XLEN-1:0];
            quot <= {quot[XLEN-2:0], div_ge};
          end else if (prod[0]) begin
            prod <= {mul_sum, prod[XLEN-1:1]};
          end else begin
            prod <= {1'b0, prod[2*XLEN-1:1]};
          end
          cnt <= cnt - 7'd1;
          if (cnt == 7'd1) state <= FIX;
        end
        FIX: begin
          io.out_result <= fix_result;
          io.out_valid  <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (io.out_ready) begin
            io.out_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors push expected result and
// completion cycle; an independent monitor pops and checks on each new out_valid.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic rst, flush;
  logic busy;

  muldiv_seq_if #(.XLEN(64)) io ();

  muldiv_seq #(.XLEN(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .io    (io),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    acc_cyc  = 0;

  localparam int NV = 22;
  logic [2:0]  v_sel [NV] = '{3'b100, 3'b110, 3'b111, 3'b101, 3'b101, 3'b101, 3'b110, 3'b100,
                              3'b100, 3'b110, 3'b100, 3'b000, 3'b001, 3'b011, 3'b010, 3'b000,
                              3'b000, 3'b000, 3'b011, 3'b100, 3'b110, 3'b111};
  logic        v_w   [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                              1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [63:0] v_a   [NV] = '{64'hFFFFFFFFFFFFFFF9, 64'hFFFFFFFFFFFFFFF9, 64'h0000000080000007,
                              64'h0000000080000007, 64'h12345678F0000001, 64'd5, 64'd5, 64'd7,
                              64'h8000000000000000, 64'h8000000000000000, 64'hFFFFFFFF80000000,
                              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                              64'hFFFFFFFFFFFFFFFF, 64'h000000007FFFFFFF, 64'h00000000FFFFFFFD,
                              64'd3, 64'h8000000000000000, 64'd100, 64'h00000000FFFFFF9C,
                              64'd1000};
  logic [63:0] v_b   [NV] = '{64'd2, 64'd2, 64'h10, 64'h10, 64'd1, 64'd0, 64'd0, 64'h100000000,
                              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                              64'hFFFFFFFFFFFFFFFF, 64'd2, 64'd5, 64'd5, 64'd4, 64'd7, 64'd7,
                              64'd7};
  logic [63:0] v_exp [NV] = '{64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000007,
                              64'h0000000008000000, 64'hFFFFFFFFF0000001, 64'hFFFFFFFFFFFFFFFF,
                              64'd5, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'd0,
                              64'hFFFFFFFF80000000, 64'd1, 64'd0, 64'hFFFFFFFFFFFFFFFE,
                              64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFF1,
                              64'd15, 64'd2, 64'd14, 64'hFFFFFFFFFFFFFFFE, 64'd6};
  int          v_lat [NV] = '{66, 66, 34, 34, 34, 2, 2, 2, 2, 2, 2, 66, 66, 66, 66, 34, 34,
                              66, 66, 66, 34, 66};
  string       v_nm  [NV] = '{"div_neg", "rem_neg", "remuw", "divuw", "divuw_sext", "divu_by0",
                              "rem_by0", "divw_by0", "div_ovf", "rem_ovf", "divw_ovf", "mul_m1",
                              "mulh_m1", "mulhu_m1", "mulhsu_m1", "mulw_sext", "mulw_neg",
                              "mul_small", "mulhu_big", "div_small", "remw_neg", "remu_small"};

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Cycle k after accept is the period ending at the k-th edge following it.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (io.in_valid && io.in_ready && !rst && !flush) acc_cyc <= cyc + 1;
  end

  initial begin
    logic seen = 1'b0;
    exp_t e;
    string nm;
    forever begin
      @(negedge clk);
      if (io.out_valid && !seen) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          check64("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          e  = sb_q.pop_front();
          nm = nm_q.pop_front();
          check64({nm, "_result"}, io.out_result, e.res);
          check64({nm, "_cycle"}, 64'(cyc - acc_cyc + 1), 64'(e.lat));
        end
      end
      if (!io.out_valid) seen = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] sel, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat,
                       input string nm, input logic push);
    int unsigned n = 0;
    exp_t e;
    while (!io.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check64({nm, "_accept_timeout"}, 64'd0, 64'd1);
      return;
    end
    io.in_valid = 1'b1;
    io.in_sel   = sel;
    io.in_w     = w;
    io.in_a     = a;
    io.in_b     = b;
    if (push) begin
      e.res = exp;
      e.lat = lat;
      sb_q.push_back(e);
      nm_q.push_back(nm);
    end
    @(negedge clk);
    io.in_valid = 1'b0;
    io.in_sel   = 3'($urandom);
    io.in_w     = 1'($urandom);
    io.in_a     = {$urandom, $urandom};
    io.in_b     = {$urandom, $urandom};
  endtask

  task automatic wait_done(input string nm);
    int unsigned n = 0;
    while (!(sb_q.size() == 0 && io.in_ready && !io.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      check64({nm, "_done_timeout"}, 64'd0, 64'd1);
      sb_q.delete();
      nm_q.delete();
    end
  endtask

  initial begin
    int unsigned hi_cnt;
    rst          = 1'b1;
    flush        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_sel    = '0;
    io.in_w      = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check64("reset_in_ready", 64'(io.in_ready), 64'd1);
    check64("reset_out_valid", 64'(io.out_valid), 64'd0);
    check64("reset_busy", 64'(busy), 64'd0);
    check64("reset_out_result", io.out_result, 64'd0);

    for (int i = 0; i < NV; i++) begin
      issue(v_sel[i], v_w[i], v_a[i], v_b[i], v_exp[i], v_lat[i], v_nm[i], 1'b1);
      wait_done(v_nm[i]);
    end

    // Backpressure: result and valid must hold while out_ready is low.
    io.out_ready = 1'b0;
    issue(3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFFFFFFFFFFFFFF, 2, "hold_divu", 1'b1);
    hi_cnt = 0;
    while (!io.out_valid && hi_cnt < 100) begin
      @(negedge clk);
      hi_cnt++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check64("hold_out_valid", 64'(io.out_valid), 64'd1);
      check64("hold_out_result", io.out_result, 64'hFFFFFFFFFFFFFFFF);
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    check64("release_out_valid", 64'(io.out_valid), 64'd0);
    check64("release_in_ready", 64'(io.in_ready), 64'd1);

    // Flush at CALC cycle 10, with a competing request in the flush cycle.
    issue(3'b100, 1'b0, 64'd1000, 64'd3, 64'd0, 0, "flushed", 1'b0);
    repeat (9) @(negedge clk);
    check64("pre_flush_busy", 64'(busy), 64'd1);
    flush       = 1'b1;
    io.in_valid = 1'b1;
    io.in_sel   = 3'b000;
    @(negedge clk);
    flush       = 1'b0;
    io.in_valid = 1'b0;
    check64("flush_in_ready", 64'(io.in_ready), 64'd1);
    check64("flush_busy", 64'(busy), 64'd0);
    hi_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (io.out_valid) hi_cnt++;
    end
    check64("flush_no_out_valid", 64'(hi_cnt), 64'd0);

    // Reset mid-CALC clears everything, including the previous result.
    issue(3'b011, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd7, 64'd0, 0, "reset_kill", 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check64("midrst_in_ready", 64'(io.in_ready), 64'd1);
    check64("midrst_out_valid", 64'(io.out_valid), 64'd0);
    check64("midrst_busy", 64'(busy), 64'd0);
    check64("midrst_out_result", io.out_result, 64'd0);

    issue(3'b100, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 66, "post_rst_div", 1'b1);
    wait_done("post_rst_div");
    check64("scoreboard_drain", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
